// File: rtl/ioctl_upload_streamer.sv
// Serves core-side RAM bytes to hps_io over the ioctl upload path, one byte per ioctl_rd.
// Optional running byte checksum on upload_sum is enabled with `define UPLOAD_CHECKSUM_EN.
module ioctl_upload_streamer #(
    parameter int UPLOAD_INDEX = 4,
    parameter int ADDR_W       = 10,
    parameter int SIZE         = 1024,
    parameter int MEM_LATENCY  = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              din_valid,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_q,
    output logic              overrun,
    output logic [7:0]        upload_sum
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    logic [1:0]  state;
    logic [1:0]  wait_cnt;
    logic        pend_valid;
    logic [24:0] pend_addr;
    logic        cur_in_range;

    logic        active;
    logic        rise;
    logic        running;
    logic        start;
    logic [24:0] issue_addr;
    logic        issue_in_range;
    logic        load_byte;
    logic [7:0]  load_value;

    assign active  = ioctl_upload && (ioctl_index == 8'(UPLOAD_INDEX));
    // mem_sel is the registered copy of active, so it doubles as the edge detector.
    assign rise    = active && !mem_sel;
    assign running = active && !rise;

    // The pending slot (including the implicit address-0 request) wins over a fresh ioctl_rd.
    assign issue_addr     = pend_valid ? pend_addr : ioctl_addr;
    assign issue_in_range = issue_addr < 25'(SIZE);
    assign start          = running && (state == S_IDLE) && (pend_valid || ioctl_rd);

    assign load_byte  = running && (((state == S_ISSUE) && !cur_in_range) ||
                                    ((state == S_WAIT) && (wait_cnt == 2'd0)));
    assign load_value = (state == S_WAIT) ? mem_q : 8'hFF;

    // NOTE: every register below is updated with <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 2'd0;
            pend_valid   <= 1'b0;
            pend_addr    <= 25'd0;
            cur_in_range <= 1'b0;
            ioctl_din    <= 8'h00;
            din_valid    <= 1'b0;
            mem_sel      <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            mem_sel <= active;
            mem_rd  <= 1'b0;

            if (!active) begin
                state      <= S_IDLE;
                pend_valid <= 1'b0;
            end else if (rise) begin
                state      <= S_IDLE;
                pend_valid <= 1'b1;
                pend_addr  <= 25'd0;
                overrun    <= 1'b0;
                din_valid  <= 1'b0;
            end else begin
                if (state == S_IDLE) begin
                    if (pend_valid) begin
                        pend_valid <= 1'b0;
                    end
                    if (ioctl_rd && pend_valid) begin
                        overrun <= 1'b1;
                    end
                end else if (ioctl_rd) begin
                    if (pend_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ioctl_addr;
                    end
                end

                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state        <= S_ISSUE;
                            cur_in_range <= issue_in_range;
                            if (issue_in_range) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= issue_addr[ADDR_W-1:0];
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (cur_in_range) begin
                            state    <= S_WAIT;
                            wait_cnt <= 2'(MEM_LATENCY - 1);
                        end else begin
                            state <= S_PRESENT;
                        end
                    end
                    S_WAIT: begin
                        if (wait_cnt == 2'd0) begin
                            state <= S_PRESENT;
                        end else begin
                            wait_cnt <= wait_cnt - 2'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                if (load_byte) begin
                    ioctl_din <= load_value;
                    din_valid <= 1'b1;
                end
                // A new request invalidates whatever byte is on display, even one landing this cycle.
                if (ioctl_rd) begin
                    din_valid <= 1'b0;
                end
            end
        end
    end

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else if (rise) begin
            sum_q <= 8'h00;
        end else if (load_byte) begin
            sum_q <= sum_q + load_value;
        end
    end

    assign upload_sum = sum_q;
`else
    assign upload_sum = 8'h00;
`endif

endmodule

// File: tb/tb_ioctl_upload_streamer.sv
// Self-checking bench for ioctl_upload_streamer: directed steps plus random addresses/RAM
// contents, checked against a byte-level RAM model and a served-byte checksum model.
module tb_ioctl_upload_streamer;

    localparam int LAT  = 2;
    localparam int SIZE = 1024;
    localparam int AW   = 10;
    localparam int IDX  = 4;
`ifdef UPLOAD_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          din_valid;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_q;
    logic          overrun;
    logic [7:0]    upload_sum;

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_streamer #(
        .UPLOAD_INDEX(IDX),
        .ADDR_W      (AW),
        .SIZE        (SIZE),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .din_valid   (din_valid),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_q       (mem_q),
        .overrun     (overrun),
        .upload_sum  (upload_sum)
    );

    // RAM with LAT-cycle read latency; stages not fed by a read carry random junk.
    logic [7:0] mem  [SIZE];
    logic [7:0] pipe [LAT];

    always @(posedge clk_sys) begin
        pipe[0] <= mem_rd ? mem[mem_addr] : 8'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_q = pipe[LAT-1];

    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    logic [7:0] ck_sum = 8'h00;
    logic [7:0] last_byte = 8'h00;

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        if (a < SIZE) return mem[a];
        return 8'hFF;
    endfunction

    function automatic logic [7:0] exp_sum();
        return CK ? ck_sum : 8'h00;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_din"},   32'(ioctl_din), 0);
        check({tag, "_vld"},   32'(din_valid), 0);
        check({tag, "_sel"},   32'(mem_sel), 0);
        check({tag, "_maddr"}, 32'(mem_addr), 0);
        check({tag, "_mrd"},   32'(mem_rd), 0);
        check({tag, "_ovr"},   32'(overrun), 0);
        check({tag, "_sum"},   32'(upload_sum), 0);
    endtask

    // One request from IDLE; byte latency, RAM strobe timing/address and data are checked.
    task automatic request(input int addr, input string tag);
        logic [7:0]    e;
        int            lat;
        int            nrd;
        int            rd_k;
        logic [AW-1:0] rd_addr;
        e = exp_byte(addr);
        lat = 0; nrd = 0; rd_k = 0; rd_addr = '0;
        ioctl_addr = 25'(addr);
        ioctl_rd   = 1'b1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (k == 1) begin
                ioctl_rd = 1'b0;
                check({tag, "_vclr"}, 32'(din_valid), 0);
            end
            if (mem_rd) begin
                nrd++;
                rd_k    = k;
                rd_addr = mem_addr;
            end
            if (din_valid) lat = k;
        end
        check({tag, "_lat"}, 32'(lat), (addr < SIZE) ? 2 + LAT : 2);
        check({tag, "_data"}, 32'(ioctl_din), 32'(e));
        check({tag, "_nrd"}, 32'(nrd), (addr < SIZE) ? 1 : 0);
        if (addr < SIZE) begin
            check({tag, "_rdk"}, 32'(rd_k), 1);
            check({tag, "_maddr"}, 32'(rd_addr), 32'(addr % SIZE));
        end
        ck_sum    = ck_sum + e;
        last_byte = e;
        check({tag, "_sum"}, 32'(upload_sum), 32'(exp_sum()));
        tick();
    endtask

    // Raise upload; expect mem_sel next cycle, the address-0 strobe one later, then byte 0.
    task automatic start_upload(input string tag);
        int lat;
        ioctl_index  = 8'(IDX);
        ioctl_upload = 1'b1;
        tick();
        ck_sum = 8'h00;
        check({tag, "_sel"}, 32'(mem_sel), 1);
        check({tag, "_ovr"}, 32'(overrun), 0);
        check({tag, "_vld"}, 32'(din_valid), 0);
        check({tag, "_sum0"}, 32'(upload_sum), 0);
        tick();
        check({tag, "_mrd"}, 32'(mem_rd), 1);
        check({tag, "_maddr"}, 32'(mem_addr), 0);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick();
            if (din_valid) lat = k;
        end
        check({tag, "_lat"}, 32'(lat), LAT + 1);
        check({tag, "_b0"}, 32'(ioctl_din), 32'(mem[0]));
        ck_sum    = ck_sum + mem[0];
        last_byte = mem[0];
        check({tag, "_sum"}, 32'(upload_sum), 32'(exp_sum()));
        tick();
    endtask

    task automatic stop_upload();
        ioctl_upload = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, b, c, addr;
        int rd_ks[$];
        int rd_as[$];
        int cnt_sel, cnt_rd, cnt_vld;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'(IDX);
        ioctl_rd     = 1'b0;
        ioctl_addr   = 25'd0;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'(i) ^ 8'h5A;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Directed: prefetch, in-range byte 3, out-of-range boundary.
        start_upload("up1");
        request(3, "addr3");
        request(SIZE - 1, "addr_last");
        request(SIZE, "addr_oor");

        // Random RAM contents and addresses, in and out of range.
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 8; n++) begin
            addr = int'($urandom_range(0, SIZE + 63));
            request(addr, $sformatf("rnd%0d", n));
        end

        // Three consecutive pulses: two served back to back, the third dropped.
        a = int'($urandom_range(0, SIZE - 1));
        b = int'($urandom_range(0, SIZE - 1));
        c = int'($urandom_range(0, SIZE - 1));
        mem[a] = 8'($urandom);
        mem[b] = mem[a] ^ 8'h3C;
        ioctl_addr = 25'(a);
        ioctl_rd   = 1'b1;
        for (int k = 1; k <= 5 + 2 * LAT + 6; k++) begin
            tick();
            if (mem_rd) begin
                rd_ks.push_back(k);
                rd_as.push_back(int'(mem_addr));
            end
            if (k == 2 + LAT) check("b2b_first", 32'(ioctl_din), 32'(mem[a]));
            if (k == 5 + 2 * LAT) begin
                check("b2b_second", 32'(ioctl_din), 32'(mem[b]));
                check("b2b_vld", 32'(din_valid), 1);
            end
            if (k == 1) ioctl_addr = 25'(b);
            if (k == 2) ioctl_addr = 25'(c);
            if (k == 3) ioctl_rd = 1'b0;
        end
        check("b2b_nrd", 32'(rd_ks.size()), 2);
        if (rd_ks.size() == 2) begin
            check("b2b_rd0_k", 32'(rd_ks[0]), 1);
            check("b2b_rd1_k", 32'(rd_ks[1]), 4 + LAT);
            check("b2b_rd1_a", 32'(rd_as[1]), 32'(b));
        end
        check("b2b_ovr", 32'(overrun), 1);
        ck_sum    = ck_sum + mem[a] + mem[b];
        last_byte = mem[b];
        check("b2b_sum", 32'(upload_sum), 32'(exp_sum()));

        // Overrun stays set until the next upload start clears it.
        request(int'($urandom_range(0, SIZE - 1)), "post_ovr");
        check("ovr_sticky", 32'(overrun), 1);
        stop_upload();
        start_upload("up2");

        // Drop upload during WAIT: fetch abandoned, displayed byte and sum untouched.
        addr = int'($urandom_range(1, SIZE - 1));
        mem[addr] = last_byte ^ 8'h80;
        ioctl_addr = 25'(addr);
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        ioctl_upload = 1'b0;
        tick();
        check("drop_sel", 32'(mem_sel), 0);
        check("drop_mrd", 32'(mem_rd), 0);
        repeat (LAT + 3) tick();
        check("drop_din", 32'(ioctl_din), 32'(last_byte));
        check("drop_vld", 32'(din_valid), 0);
        check("drop_sum", 32'(upload_sum), 32'(exp_sum()));
        ioctl_addr = 25'(addr);
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        cnt_sel = 0; cnt_rd = 0;
        for (int k = 0; k < 8; k++) begin
            if (mem_sel) cnt_sel++;
            if (mem_rd) cnt_rd++;
            tick();
        end
        check("idle_rd_sel", 32'(cnt_sel), 0);
        check("idle_rd_mrd", 32'(cnt_rd), 0);

        // Checksum over {01,02,03,FF}: wraps to 05 when enabled, 00 otherwise.
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFF;
        start_upload("up3");
        request(1, "ck1");
        request(2, "ck2");
        request(3, "ck3");
        check("ck_total", 32'(upload_sum), CK ? 32'h05 : 32'h00);

        // Reset asserted during WAIT.
        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        check_all_zero("rst_wait");
        ioctl_upload = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        ck_sum = 8'h00;

        // Upload for another index: the block stays silent.
        ioctl_index  = 8'd0;
        ioctl_upload = 1'b1;
        cnt_sel = 0; cnt_rd = 0; cnt_vld = 0;
        for (int k = 0; k < 12; k++) begin
            ioctl_addr = 25'd3;
            ioctl_rd   = (k == 3 || k == 7);
            tick();
            if (mem_sel) cnt_sel++;
            if (mem_rd) cnt_rd++;
            if (din_valid) cnt_vld++;
        end
        ioctl_rd = 1'b0;
        check("idx0_sel", 32'(cnt_sel), 0);
        check("idx0_mrd", 32'(cnt_rd), 0);
        check("idx0_vld", 32'(cnt_vld), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
